operand_issue: RTL and testbench

//   Initiator side of the 16x16 register file. Decodes 16-bit instructions
//   (op|rd|ra|rb, 4 bits each), drives the regfile read selectors and

---
 rtl/operand_issue.sv | 139 +++++++++++++
 tb/tb_operand_issue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue.sv
// Operand issue stage: decode, scoreboard, forwarding and the
// one-entry valid/ready operand bundle register.
module operand_issue #(
   parameter logic [15:0] WB_MASK = 16'h0FFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ins,
   input  logic        ins_valid,
   output logic        ins_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_op,
   output logic [3:0]  out_rd,
   output logic [15:0] out_a,
   output logic [15:0] out_b,
   input  logic        wb_valid,
   input  logic [3:0]  wb_sel,
   input  logic [15:0] wb_data,
   output logic [3:0]  rf_selRs,
   output logic [3:0]  rf_selRt,
   input  logic [15:0] rf_rs,
   input  logic [15:0] rf_rt,
   output logic        rf_wen,
   output logic [3:0]  rf_selRd,
   output logic [15:0] rf_rd
);

   logic [3:0]  insOp;
   logic [3:0]  insRd;
   logic [3:0]  insRa;
   logic [3:0]  insRb;
   logic        clr;
   logic        wr;
   logic        srcOkA;
   logic        srcOkB;
   logic        dstOk;
   logic        space;
   logic        issue;
   logic [15:0] opA;
   logic [15:0] opB;
   logic [15:0] busy;
   logic [15:0] busyNext;

   // A register is usable when it is R0, idle, or retiring right now.
   function automatic logic regOk(input logic [3:0] r,
                                  input logic [15:0] bsy,
                                  input logic c,
                                  input logic [3:0] sel);
      regOk = (r == 4'd0) || !bsy[r] || (c && sel == r);
   endfunction

   // Operand value with R0 hardwired to zero and same-cycle bypass.
   function automatic logic [15:0] fwd(input logic [3:0] r,
                                       input logic c,
                                       input logic [3:0] sel,
                                       input logic [15:0] wd,
                                       input logic [15:0] rfv);
      if (r == 4'd0)
         fwd = 16'h0000;
      else if (c && sel == r)
         fwd = wd;
      else
         fwd = rfv;
   endfunction

   // Instruction field split and regfile read selectors.
   always_comb begin
      insOp    = ins[15:12];
      insRd    = ins[11:8];
      insRa    = ins[7:4];
      insRb    = ins[3:0];
      rf_selRs = ins[7:4];
      rf_selRt = ins[3:0];
   end

   // Writeback steering; the write port is gated off during reset.
   always_comb begin
      clr      = wb_valid && (wb_sel != 4'd0);
      rf_wen   = rst && clr;
      rf_selRd = wb_sel;
      rf_rd    = wb_data;
   end

   // Hazard checks and the accept handshake.
   always_comb begin
      wr        = WB_MASK[insOp] && (insRd != 4'd0);
      srcOkA    = regOk(insRa, busy, clr, wb_sel);
      srcOkB    = regOk(insRb, busy, clr, wb_sel);
      dstOk     = !wr || regOk(insRd, busy, clr, wb_sel);
      space     = !out_valid || out_ready;
      ins_ready = rst && space && srcOkA && srcOkB && dstOk;
      issue     = ins_valid && ins_ready;
   end

   // Operand selection with writeback forwarding.
   always_comb begin
      opA = fwd(insRa, clr, wb_sel, wb_data, rf_rs);
      opB = fwd(insRb, clr, wb_sel, wb_data, rf_rt);
   end

   // Scoreboard update: retire first, then claim, so a claim wins.
   always_comb begin
      busyNext = busy;
      if (clr)
         busyNext[wb_sel] = 1'b0;
      if (issue && wr)
         busyNext[insRd] = 1'b1;
      busyNext[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         busy <= 16'h0000;
      else
         busy <= busyNext;
   end

   // One-entry output bundle: load on issue, drain when taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_op    <= 4'd0;
         out_rd    <= 4'd0;
         out_a     <= 16'h0000;
         out_b     <= 16'h0000;
      end else if (issue) begin
         out_valid <= 1'b1;
         out_op    <= insOp;
         out_rd    <= insRd;
         out_a     <= opA;
         out_b     <= opB;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue with a behavioural regfile.
// Expected values are hand-computed per step.
module tb_operand_issue;

   logic        clk;
   logic        rst;
   logic [15:0] ins;
   logic        ins_valid;
   logic        ins_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [3:0]  out_rd;
   logic [15:0] out_a;
   logic [15:0] out_b;
   logic        wb_valid;
   logic [3:0]  wb_sel;
   logic [15:0] wb_data;
   logic [3:0]  rf_selRs;
   logic [3:0]  rf_selRt;
   logic [15:0] rf_rs;
   logic [15:0] rf_rt;
   logic        rf_wen;
   logic [3:0]  rf_selRd;
   logic [15:0] rf_rd;

   logic [15:0] rf [16];
   int          nChecks;
   int          nPass;

   operand_issue dut (
      .clk       (clk),
      .rst       (rst),
      .ins       (ins),
      .ins_valid (ins_valid),
      .ins_ready (ins_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op    (out_op),
      .out_rd    (out_rd),
      .out_a     (out_a),
      .out_b     (out_b),
      .wb_valid  (wb_valid),
      .wb_sel    (wb_sel),
      .wb_data   (wb_data),
      .rf_selRs  (rf_selRs),
      .rf_selRt  (rf_selRt),
      .rf_rs     (rf_rs),
      .rf_rt     (rf_rt),
      .rf_wen    (rf_wen),
      .rf_selRd  (rf_selRd),
      .rf_rd     (rf_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural regfile: combinational read, R0 reads zero.
   assign rf_rs = (rf_selRs == 4'd0) ? 16'h0000 : rf[rf_selRs];
   assign rf_rt = (rf_selRt == 4'd0) ? 16'h0000 : rf[rf_selRt];

   always @(posedge clk)
      if (rf_wen)
         rf[rf_selRd] <= rf_rd;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      nChecks++;
      if (got === exp)
         nPass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      nChecks   = 0;
      nPass     = 0;
      for (int i = 0; i < 16; i++)
         rf[i] = 16'h0000;
      rf[2]     = 16'h00AA;
      rf[3]     = 16'h0055;
      rst       = 1'b0;
      ins       = 16'h0000;
      ins_valid = 1'b0;
      out_ready = 1'b0;
      wb_valid  = 1'b0;
      wb_sel    = 4'd0;
      wb_data   = 16'h0000;
      tick();
      tick();

      // 1: build a held bundle, then reset mid-bundle
      rst       = 1'b1;
      ins       = 16'h0123;
      ins_valid = 1'b1;
      tick();
      check("pre_valid", {31'd0, out_valid}, 32'd1);
      check("pre_busy", {16'd0, dut.busy}, 32'h0002);
      wb_valid = 1'b1;
      wb_sel   = 4'd3;
      wb_data  = 16'hBEEF;
      rst      = 1'b0;
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {16'd0, dut.busy}, 32'h0000);
      check("rst_a", {16'd0, out_a}, 32'h0000);
      check("rst_wen", {31'd0, rf_wen}, 32'd0);
      check("rst_ready", {31'd0, ins_ready}, 32'd0);
      wb_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("rel_ready", {31'd0, ins_ready}, 32'd1);

      // 2: issue 0123
      out_ready = 1'b1;
      check("sel_rs", {28'd0, rf_selRs}, 32'd2);
      tick();
      ins_valid = 1'b0;
      check("iss_valid", {31'd0, out_valid}, 32'd1);
      check("iss_op", {28'd0, out_op}, 32'd0);
      check("iss_rd", {28'd0, out_rd}, 32'd1);
      check("iss_a", {16'd0, out_a}, 32'h00AA);
      check("iss_b", {16'd0, out_b}, 32'h0055);
      check("iss_busy", {16'd0, dut.busy}, 32'h0002);

      // 3: RAW stall then forward
      ins       = 16'h0214;
      ins_valid = 1'b1;
      #1;
      check("raw_stall", {31'd0, ins_ready}, 32'd0);
      wb_valid = 1'b1;
      wb_sel   = 4'd1;
      wb_data  = 16'h1234;
      #1;
      check("raw_ready", {31'd0, ins_ready}, 32'd1);
      check("raw_wen", {31'd0, rf_wen}, 32'd1);
      tick();
      wb_valid  = 1'b0;
      ins_valid = 1'b0;
      check("fwd_a", {16'd0, out_a}, 32'h1234);
      check("fwd_b", {16'd0, out_b}, 32'h0000);
      check("fwd_rd", {28'd0, out_rd}, 32'd2);
      check("fwd_busy", {16'd0, dut.busy}, 32'h0004);

      // 4: backpressure for three cycles
      out_ready = 1'b0;
      ins       = 16'h0356;
      ins_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_ready", {31'd0, ins_ready}, 32'd0);
         tick();
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_rd", {28'd0, out_rd}, 32'd2);
         check("bp_a", {16'd0, out_a}, 32'h1234);
      end
      out_ready = 1'b1;
      ins       = 16'h0331;
      #1;
      check("bp_rel", {31'd0, ins_ready}, 32'd1);
      tick();
      check("bp_new_rd", {28'd0, out_rd}, 32'd3);
      check("bp_new_a", {16'd0, out_a}, 32'h0055);
      check("bp_new_b", {16'd0, out_b}, 32'h1234);
      check("bp_busy", {16'd0, dut.busy}, 32'h000C);

      // 5: R0 handling with a writeback to R0
      ins      = 16'h0000;
      wb_valid = 1'b1;
      wb_sel   = 4'd0;
      wb_data  = 16'hFFFF;
      #1;
      check("r0_wen", {31'd0, rf_wen}, 32'd0);
      check("r0_ready", {31'd0, ins_ready}, 32'd1);
      tick();
      wb_valid = 1'b0;
      check("r0_a", {16'd0, out_a}, 32'h0000);
      check("r0_b", {16'd0, out_b}, 32'h0000);
      check("r0_busy", {16'd0, dut.busy}, 32'h000C);

      // 6: masked opcode does not claim rd
      ins = 16'hC510;
      tick();
      check("msk_op", {28'd0, out_op}, 32'hC);
      check("msk_a", {16'd0, out_a}, 32'h1234);
      check("msk_busy", {16'd0, dut.busy}, 32'h000C);

      // 6: WAW stall on R5
      ins = 16'h0500;
      tick();
      check("waw_busy", {16'd0, dut.busy}, 32'h002C);
      #1;
      check("waw_stall", {31'd0, ins_ready}, 32'd0);
      tick();
      check("waw_drain", {31'd0, out_valid}, 32'd0);
      check("waw_still", {31'd0, ins_ready}, 32'd0);
      wb_valid = 1'b1;
      wb_sel   = 4'd5;
      wb_data  = 16'h7777;
      #1;
      check("waw_ready", {31'd0, ins_ready}, 32'd1);
      tick();
      wb_valid  = 1'b0;
      ins_valid = 1'b0;
      check("waw_valid", {31'd0, out_valid}, 32'd1);
      check("waw_reclaim", {16'd0, dut.busy}, 32'h002C);
      check("waw_rf5", {16'd0, rf[5]}, 32'h7777);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
